dma2mfb: RTL and testbench
==========================

Name: dma2mfb

Overview:
- Converts the upstream DMA bus into separate streams: a header stream on an MVB bus and a data stream on an MFB bus.
- It is the reverse-direction counterpart of mfb2dma. It sits between the DMA upstream controller and the PCIe transaction builder.
- The MFB SOF/EOF/EOF_POS framing is computed from the length field of each DMA header.
- Headers and data are buffered independently, so the MVB and MFB outputs are decoupled.

Parameters:
- MFB_REGIONS, 2, number of MFB regions; one DMA word equals one MFB word.
- MFB_REG_WIDTH, 256, region width in bits. Item width is fixed at 32 bits (dword).
- DMA_HDR_WIDTH, 64, width of the DMA header, and of the MVB item.
- INPUT_FIFO_SIZE, 16, depth in words of the data FIFO.
- HDR_FIFO_SIZE, 8, depth in headers of the header FIFO.

Ports:
- CLK  in  1  clock.
- RESET  in  1  reset.
- RX_DMA_UP_HDR  in  DMA_HDR_WIDTH  header; valid on the SOP word.
- RX_DMA_UP_DATA  in  MFB_REGIONS*MFB_REG_WIDTH  data word.
- RX_DMA_UP_SOP  in  1  first word of a packet.
- RX_DMA_UP_EOP  in  1  last word of a packet.
- RX_DMA_UP_SRC_RDY  in  1  word valid.
- RX_DMA_UP_DST_RDY  out  1  word accepted.
- TX_MVB_UP_DATA  out  DMA_HDR_WIDTH  header (single MVB item).
- TX_MVB_UP_VLD  out  1  item valid.
- TX_MVB_UP_SRC_RDY  out  1  MVB word valid.
- TX_MVB_UP_DST_RDY  in  1  downstream ready.
- TX_MFB_UP_DATA  out  MFB_REGIONS*MFB_REG_WIDTH  data.
- TX_MFB_UP_SOF  out  MFB_REGIONS  per-region start of frame.
- TX_MFB_UP_EOF  out  MFB_REGIONS  per-region end of frame.
- TX_MFB_UP_EOF_POS  out  MFB_REGIONS*log2(MFB_REG_WIDTH/32)  per-region last dword index.
- TX_MFB_UP_SRC_RDY  out  1  MFB word valid.
- TX_MFB_UP_DST_RDY  in  1  downstream ready.
- ERR  out  1  sticky framing-error flag.

Behaviour:
- One clock. Reset is synchronous and active-high: RESET sampled high on a CLK rising edge resets the block.
- Reset values:
  - all SRC_RDY and VLD outputs 0; ERR 0;
  - both FIFOs empty; FSM in IDLE; word counter 0;
  - RX_DMA_UP_DST_RDY 0 while RESET is high.
- Accept condition: a word is accepted when SRC_RDY=1 and DST_RDY=1.
- RX_DMA_UP_DST_RDY = data FIFO not full AND header FIFO not full. The condition is registered-free, and is applied regardless of SOP so that it stays simple.
- Length field: header bits [10:0] give the length L in dwords. L=0 is interpreted as 2048.
- With D = MFB_REGIONS*MFB_REG_WIDTH/32 dwords per word:
  - expected word count W = ceil(L/D);
  - last dword index I = (L-1) mod D;
  - EOF region = I / (MFB_REG_WIDTH/32);
  - EOF_POS = I mod (MFB_REG_WIDTH/32).
- FSM IDLE:
  - An accepted SOP word pushes the header into the header FIFO and latches W and I.
  - If W=1 and EOP=1, the FSM stays in IDLE. Otherwise it goes to PKT with counter=1.
  - An accepted non-SOP word in IDLE is dropped and sets ERR.
- FSM PKT:
  - Each accepted word increments the counter.
  - On an accepted word with counter+1=W and EOP=1, the FSM goes to IDLE.
- Framing on the written MFB word:
  - SOF is set in region 0 only, on the SOP word.
  - EOF is set on the word that closes the packet.
- Error cases:
  - EOP arrives before W words: set ERR, force EOF in the last region with EOF_POS at its maximum, go to IDLE.
  - Counter reaches W without EOP: set EOF at the computed position, set ERR, go to IDLE. The remaining words are dropped until the next SOP.
  - SOP while in PKT: close the current packet with a forced EOF on the previous word. This is not possible once that word has been written, so the open packet is instead marked by ERR and the new packet is started normally.
- Data FIFO: stores data, SOF, EOF and EOF_POS. It is first-word-fall-through, so an accepted word appears on TX_MFB one cycle after acceptance.
- Header FIFO: first-word-fall-through with the same one-cycle latency. TX_MVB_UP_VLD = TX_MVB_UP_SRC_RDY.
- The outputs pop independently when SRC_RDY=1 and DST_RDY=1.
- Simultaneous push and pop on a full FIFO: the FIFO is not ready for the push (DST_RDY low). Simultaneous push and pop on an empty FIFO is legal.
- ERR clears only on reset.
- Reset mid-packet: all buffered data and headers are discarded. The next word must carry SOP.

Decomposition:
- Package dma2mfb_pkg holds:
  - header field offsets (LEN_LO=0, LEN_HI=10);
  - ITEM_WIDTH=32;
  - derived constants D, REGION_ITEMS and EOF_POS_WIDTH;
  - the FSM state enum {IDLE, PKT}.
- One natural sub-module: dma2mfb_fifo. It is a parameterised first-word-fall-through FIFO (width, depth, full/empty) and is instantiated twice, once for data and once for headers.

Test Plan (MFB_REGIONS=2, MFB_REG_WIDTH=256, so D=16 and region=8 dwords):
- L=1, single word with SOP+EOP -> one MVB header; MFB SOF=01, EOF=01, EOF_POS region0=0; ERR=0.
- L=20, two words -> word 1 SOF=01 EOF=00; word 2 EOF=01, EOF_POS region0=3. L=16 on one word -> EOF=10, EOF_POS region1=7.
- TX_MFB_UP_DST_RDY=0, stream of 2-word packets -> RX_DMA_UP_DST_RDY falls after 16 words accepted. Releasing backpressure delivers all words in order with no loss or duplication.
- HDR_FIFO_SIZE=8 with TX_MVB_UP_DST_RDY=0, nine 1-word packets -> the 9th SOP is stalled until one header pops. The MFB output continues meanwhile.
- L=40 (W=3) with EOP on word 2 -> ERR=1; word 2 gets EOF=10 with EOF_POS region1=7; the next SOP packet is framed correctly.
- RESET asserted one cycle mid-packet -> all SRC_RDY=0 next cycle. A following L=1 packet is delivered correctly and ERR stays 0.

Source files
------------

// File: rtl/dma2mfb_pkg.sv
// Shared constants, header field layout and FSM state type for the DMA-to-MVB/MFB splitter.
// Default geometry lives here; the top derives its own constants from its parameters.
package dma2mfb_pkg;

  localparam int ITEM_WIDTH = 32;
  localparam int LEN_LO     = 0;
  localparam int LEN_HI     = 10;
  localparam int MAX_LEN    = 2048;

  localparam int DEF_REGIONS   = 2;
  localparam int DEF_REG_WIDTH = 256;
  localparam int DEF_HDR_WIDTH = 64;

  localparam int REGION_ITEMS  = DEF_REG_WIDTH / ITEM_WIDTH;
  localparam int D             = DEF_REGIONS * REGION_ITEMS;
  localparam int EOF_POS_WIDTH = (REGION_ITEMS > 1) ? $clog2(REGION_ITEMS) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } state_t;

endpackage

// File: rtl/dma2mfb_if.sv
// Bus bundles for the splitter: upstream DMA input, MVB header output, MFB data output.
// master drives the payload and src_rdy, slave returns dst_rdy.
interface dma2mfb_dma_if #(
  parameter int DATA_WIDTH = 512,
  parameter int HDR_WIDTH  = 64
);
  logic [HDR_WIDTH-1:0]  hdr;
  logic [DATA_WIDTH-1:0] data;
  logic                  sop;
  logic                  eop;
  logic                  src_rdy;
  logic                  dst_rdy;

  modport master (output hdr, data, sop, eop, src_rdy, input dst_rdy);
  modport slave  (input hdr, data, sop, eop, src_rdy, output dst_rdy);
endinterface

interface dma2mfb_mvb_if #(
  parameter int ITEM_WIDTH = 64
);
  logic [ITEM_WIDTH-1:0] data;
  logic                  vld;
  logic                  src_rdy;
  logic                  dst_rdy;

  modport master (output data, vld, src_rdy, input dst_rdy);
  modport slave  (input data, vld, src_rdy, output dst_rdy);
endinterface

interface dma2mfb_mfb_if
  import dma2mfb_pkg::*;
#(
  parameter int REGIONS      = 2,
  parameter int REGION_WIDTH = 256
);
  localparam int RI  = REGION_WIDTH / ITEM_WIDTH;
  localparam int EPW = (RI > 1) ? $clog2(RI) : 1;

  logic [REGIONS*REGION_WIDTH-1:0] data;
  logic [REGIONS-1:0]              sof;
  logic [REGIONS-1:0]              eof;
  logic [REGIONS*EPW-1:0]          eof_pos;
  logic                            src_rdy;
  logic                            dst_rdy;

  modport master (output data, sof, eof, eof_pos, src_rdy, input dst_rdy);
  modport slave  (input data, sof, eof, eof_pos, src_rdy, output dst_rdy);
endinterface

// File: rtl/dma2mfb_fifo.sv
// First-word-fall-through FIFO: a write is visible at rd_data one cycle later.
// Writes are ignored while full, reads while empty; push+pop on empty is legal.
module dma2mfb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr_ok;
  logic             rd_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + AW'(1);
      end
      if (rd_ok) begin
        rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + AW'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dma2mfb.sv
// Splits the upstream DMA bus into an MVB header stream and an MFB data stream, framing from the header length.
// Outputs lag acceptance by one cycle; input stalls when either FIFO is full, outputs drain independently.
module dma2mfb
  import dma2mfb_pkg::*;
#(
  parameter int MFB_REGIONS     = DEF_REGIONS,
  parameter int MFB_REG_WIDTH   = DEF_REG_WIDTH,
  parameter int DMA_HDR_WIDTH   = DEF_HDR_WIDTH,
  parameter int INPUT_FIFO_SIZE = 16,
  parameter int HDR_FIFO_SIZE   = 8
) (
  input  logic         clk,
  input  logic         reset,
  dma2mfb_dma_if.slave rx_dma,
  dma2mfb_mvb_if.master tx_mvb,
  dma2mfb_mfb_if.master tx_mfb,
  output logic         err
);
  localparam int DW  = MFB_REGIONS * MFB_REG_WIDTH;
  localparam int RI  = MFB_REG_WIDTH / ITEM_WIDTH;
  localparam int WI  = MFB_REGIONS * RI;
  localparam int EPW = (RI > 1) ? $clog2(RI) : 1;
  localparam int IW  = (WI > 1) ? $clog2(WI) : 1;
  localparam int CW  = $clog2(MAX_LEN) + 1;

  typedef struct packed {
    logic [DW-1:0]              data;
    logic [MFB_REGIONS-1:0]     sof;
    logic [MFB_REGIONS-1:0]     eof;
    logic [MFB_REGIONS*EPW-1:0] eof_pos;
  } mfb_word_t;

  state_t    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [CW-1:0] w_reg, w_n;
  logic [IW-1:0] i_reg, i_n;

  logic [LEN_HI-LEN_LO:0] len_f;
  logic [CW-1:0]          len_full;
  logic [CW-1:0]          w_calc;
  logic [IW-1:0]          i_calc;

  logic acc;
  logic d_push, h_push, d_full, h_full, d_empty, h_empty;
  logic err_set, close_calc, close_force;
  logic [IW-1:0]              close_i;
  logic [MFB_REGIONS-1:0]     wr_sof;
  logic [MFB_REGIONS-1:0]     wr_eof;
  logic [MFB_REGIONS*EPW-1:0] wr_eof_pos;
  mfb_word_t                  wr_word, rd_word;

  // A zero length field encodes the maximum transfer size.
  assign len_f    = rx_dma.hdr[LEN_HI:LEN_LO];
  assign len_full = (len_f == '0) ? CW'(MAX_LEN) : CW'(len_f);
  assign w_calc   = CW'((len_full + CW'(WI-1)) / CW'(WI));
  assign i_calc   = IW'((len_full - CW'(1)) % CW'(WI));

  assign rx_dma.dst_rdy = !reset && !d_full && !h_full;
  assign acc            = rx_dma.src_rdy && rx_dma.dst_rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      w_reg <= '0;
      i_reg <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      w_reg <= w_n;
      i_reg <= i_n;
      if (err_set) begin
        err <= 1'b1;
      end
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    w_n         = w_reg;
    i_n         = i_reg;
    d_push      = 1'b0;
    h_push      = 1'b0;
    err_set     = 1'b0;
    wr_sof      = '0;
    close_calc  = 1'b0;
    close_force = 1'b0;
    close_i     = i_reg;
    if (acc) begin
      if (rx_dma.sop) begin
        // A SOP inside an open packet cannot retro-close the word already written; flag it instead.
        h_push    = 1'b1;
        d_push    = 1'b1;
        wr_sof[0] = 1'b1;
        w_n       = w_calc;
        i_n       = i_calc;
        close_i   = i_calc;
        cnt_n     = CW'(1);
        if (state == PKT) begin
          err_set = 1'b1;
        end
        if (w_calc == CW'(1)) begin
          close_calc = 1'b1;
          state_n    = IDLE;
          if (!rx_dma.eop) begin
            err_set = 1'b1;
          end
        end else if (rx_dma.eop) begin
          close_force = 1'b1;
          err_set     = 1'b1;
          state_n     = IDLE;
        end else begin
          state_n = PKT;
        end
      end else if (state == IDLE) begin
        err_set = 1'b1;
      end else begin
        d_push = 1'b1;
        cnt_n  = cnt + CW'(1);
        if (cnt + CW'(1) == w_reg) begin
          close_calc = 1'b1;
          state_n    = IDLE;
          if (!rx_dma.eop) begin
            err_set = 1'b1;
          end
        end else if (rx_dma.eop) begin
          close_force = 1'b1;
          err_set     = 1'b1;
          state_n     = IDLE;
        end
      end
    end
  end

  always_comb begin
    wr_eof     = '0;
    wr_eof_pos = '0;
    if (close_force) begin
      wr_eof[MFB_REGIONS-1]                      = 1'b1;
      wr_eof_pos[(MFB_REGIONS-1)*EPW +: EPW]     = '1;
    end else if (close_calc) begin
      for (int r = 0; r < MFB_REGIONS; r++) begin
        if (int'(close_i) / RI == r) begin
          wr_eof[r]                  = 1'b1;
          wr_eof_pos[r*EPW +: EPW]   = EPW'(int'(close_i) % RI);
        end
      end
    end
  end

  always_comb begin
    wr_word         = '0;
    wr_word.data    = rx_dma.data;
    wr_word.sof     = wr_sof;
    wr_word.eof     = wr_eof;
    wr_word.eof_pos = wr_eof_pos;
  end

  dma2mfb_fifo #(
    .WIDTH ($bits(mfb_word_t)),
    .DEPTH (INPUT_FIFO_SIZE)
  ) u_data_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (d_push),
    .wr_data (wr_word),
    .full    (d_full),
    .rd_en   (tx_mfb.dst_rdy),
    .rd_data (rd_word),
    .empty   (d_empty)
  );

  dma2mfb_fifo #(
    .WIDTH (DMA_HDR_WIDTH),
    .DEPTH (HDR_FIFO_SIZE)
  ) u_hdr_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (h_push),
    .wr_data (rx_dma.hdr),
    .full    (h_full),
    .rd_en   (tx_mvb.dst_rdy),
    .rd_data (tx_mvb.data),
    .empty   (h_empty)
  );

  assign tx_mfb.data    = rd_word.data;
  assign tx_mfb.sof     = rd_word.sof;
  assign tx_mfb.eof     = rd_word.eof;
  assign tx_mfb.eof_pos = rd_word.eof_pos;
  assign tx_mfb.src_rdy = !d_empty;

  assign tx_mvb.src_rdy = !h_empty;
  assign tx_mvb.vld     = !h_empty;

endmodule

// File: tb/tb_dma2mfb.sv
// Directed bench for dma2mfb with 2x256-bit MFB words (16 dwords per word, 8 per region).
module tb_dma2mfb;
  import dma2mfb_pkg::*;

  logic clk;
  logic reset;
  logic err;
  int   total;
  int   bad;

  dma2mfb_dma_if #(.DATA_WIDTH(512), .HDR_WIDTH(64)) dma_bus ();
  dma2mfb_mvb_if #(.ITEM_WIDTH(64)) mvb_bus ();
  dma2mfb_mfb_if #(.REGIONS(2), .REGION_WIDTH(256)) mfb_bus ();

  dma2mfb #(
    .MFB_REGIONS     (2),
    .MFB_REG_WIDTH   (256),
    .DMA_HDR_WIDTH   (64),
    .INPUT_FIFO_SIZE (16),
    .HDR_FIFO_SIZE   (8)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .rx_dma (dma_bus),
    .tx_mvb (mvb_bus),
    .tx_mfb (mfb_bus),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [599:0] obs, input logic [599:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] mkd(input logic [15:0] id);
    return {32{id}};
  endfunction

  function automatic logic [63:0] mkh(input logic [31:0] tag, input logic [10:0] len);
    return {tag, 21'h0, len};
  endfunction

  function automatic logic [599:0] mfbw();
    return 600'({mfb_bus.sof, mfb_bus.eof, mfb_bus.eof_pos, mfb_bus.data});
  endfunction

  function automatic logic [599:0] expw(input logic [1:0] sof, input logic [1:0] eof,
                                        input logic [5:0] pos, input logic [511:0] d);
    return 600'({sof, eof, pos, d});
  endfunction

  task automatic send(input logic [63:0] h, input logic [511:0] d, input logic s, input logic e);
    int n;
    dma_bus.hdr     = h;
    dma_bus.data    = d;
    dma_bus.sop     = s;
    dma_bus.eop     = e;
    dma_bus.src_rdy = 1'b1;
    n = 0;
    while (dma_bus.dst_rdy !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL send_timeout: observed=dst_rdy stuck low expected=accept within 50 cycles");
    end else begin
      tick();
    end
    dma_bus.src_rdy = 1'b0;
  endtask

  task automatic pop_mfb();
    mfb_bus.dst_rdy = 1'b1;
    tick();
    mfb_bus.dst_rdy = 1'b0;
  endtask

  task automatic pop_mvb();
    mvb_bus.dst_rdy = 1'b1;
    tick();
    mvb_bus.dst_rdy = 1'b0;
  endtask

  task automatic pop_both();
    mfb_bus.dst_rdy = 1'b1;
    mvb_bus.dst_rdy = 1'b1;
    tick();
    mfb_bus.dst_rdy = 1'b0;
    mvb_bus.dst_rdy = 1'b0;
  endtask

  initial begin
    total           = 0;
    bad             = 0;
    reset           = 1'b1;
    dma_bus.hdr     = '0;
    dma_bus.data    = '0;
    dma_bus.sop     = 1'b0;
    dma_bus.eop     = 1'b0;
    dma_bus.src_rdy = 1'b0;
    mvb_bus.dst_rdy = 1'b0;
    mfb_bus.dst_rdy = 1'b0;

    // reset state
    repeat (3) tick();
    check("rst_dst_rdy", dma_bus.dst_rdy, 1'b0);
    check("rst_src_rdy", {mfb_bus.src_rdy, mvb_bus.src_rdy, mvb_bus.vld}, 3'b000);
    check("rst_err", err, 1'b0);
    reset = 1'b0;
    #1;
    check("post_rst_dst_rdy", dma_bus.dst_rdy, 1'b1);

    // L=1 single word
    send(mkh(32'hA0000001, 11'd1), mkd(16'h0001), 1'b1, 1'b1);
    check("l1_mfb", mfbw(), expw(2'b01, 2'b01, 6'b000000, mkd(16'h0001)));
    check("l1_mvb", {mvb_bus.src_rdy, mvb_bus.vld, mvb_bus.data}, {2'b11, mkh(32'hA0000001, 11'd1)});
    check("l1_err", err, 1'b0);
    pop_both();
    check("l1_drained", {mfb_bus.src_rdy, mvb_bus.src_rdy}, 2'b00);

    // L=20 over two words, then L=16 ending in region 1
    send(mkh(32'hB0000001, 11'd20), mkd(16'h0002), 1'b1, 1'b0);
    send(mkh(32'hB0000001, 11'd20), mkd(16'h0003), 1'b0, 1'b1);
    check("l20_w1", mfbw(), expw(2'b01, 2'b00, 6'b000000, mkd(16'h0002)));
    pop_mfb();
    check("l20_w2", mfbw(), expw(2'b00, 2'b01, 6'b000011, mkd(16'h0003)));
    pop_mfb();
    check("l20_mvb", {mvb_bus.src_rdy, mvb_bus.data}, {1'b1, mkh(32'hB0000001, 11'd20)});
    pop_mvb();
    send(mkh(32'hC0000001, 11'd16), mkd(16'h0004), 1'b1, 1'b1);
    check("l16_w1", mfbw(), expw(2'b01, 2'b10, 6'b111000, mkd(16'h0004)));
    pop_both();
    check("l16_err", err, 1'b0);

    // data FIFO backpressure: 8 two-word packets fill 16 entries
    mvb_bus.dst_rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      send(mkh(32'h10000000 + 32'(k), 11'd20), mkd(16'(16'h0100 + 2*k)), 1'b1, 1'b0);
      send(mkh(32'h10000000 + 32'(k), 11'd20), mkd(16'(16'h0101 + 2*k)), 1'b0, 1'b1);
    end
    check("bp_dst_rdy_low", dma_bus.dst_rdy, 1'b0);
    mvb_bus.dst_rdy = 1'b0;
    mfb_bus.dst_rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0)
        check($sformatf("bp_word%0d", i), mfbw(), expw(2'b01, 2'b00, 6'b000000, mkd(16'(16'h0100 + i))));
      else
        check($sformatf("bp_word%0d", i), mfbw(), expw(2'b00, 2'b01, 6'b000011, mkd(16'(16'h0100 + i))));
      tick();
    end
    mfb_bus.dst_rdy = 1'b0;
    check("bp_drained", {mfb_bus.src_rdy, dma_bus.dst_rdy}, 2'b01);

    // header FIFO backpressure: 9th SOP waits for one header pop
    mfb_bus.dst_rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      send(mkh(32'hD0000000 + 32'(k), 11'd1), mkd(16'(16'h0200 + k)), 1'b1, 1'b1);
    end
    check("hf_mfb_flows", mfbw(), expw(2'b01, 2'b01, 6'b000000, mkd(16'h0207)));
    check("hf_dst_rdy_low", dma_bus.dst_rdy, 1'b0);
    dma_bus.hdr     = mkh(32'hD0000008, 11'd1);
    dma_bus.data    = mkd(16'h0208);
    dma_bus.sop     = 1'b1;
    dma_bus.eop     = 1'b1;
    dma_bus.src_rdy = 1'b1;
    tick();
    tick();
    check("hf_stalled", {dma_bus.dst_rdy, mfb_bus.src_rdy}, 2'b00);
    pop_mvb();
    check("hf_released", dma_bus.dst_rdy, 1'b1);
    check("hf_mvb_head", mvb_bus.data, mkh(32'hD0000001, 11'd1));
    tick();
    dma_bus.src_rdy = 1'b0;
    check("hf_9th_word", mfbw(), expw(2'b01, 2'b01, 6'b000000, mkd(16'h0208)));
    mvb_bus.dst_rdy = 1'b1;
    repeat (9) tick();
    mvb_bus.dst_rdy = 1'b0;
    mfb_bus.dst_rdy = 1'b0;
    check("hf_drained", {mfb_bus.src_rdy, mvb_bus.src_rdy}, 2'b00);

    // L=40 (W=3) with early EOP on word 2
    send(mkh(32'hE0000001, 11'd40), mkd(16'h0300), 1'b1, 1'b0);
    send(mkh(32'hE0000001, 11'd40), mkd(16'h0301), 1'b0, 1'b1);
    check("early_eop_err", err, 1'b1);
    check("early_w1", mfbw(), expw(2'b01, 2'b00, 6'b000000, mkd(16'h0300)));
    pop_mfb();
    check("early_w2", mfbw(), expw(2'b00, 2'b10, 6'b111000, mkd(16'h0301)));
    pop_mfb();
    send(mkh(32'hE0000002, 11'd1), mkd(16'h0302), 1'b1, 1'b1);
    check("after_err_word", mfbw(), expw(2'b01, 2'b01, 6'b000000, mkd(16'h0302)));
    check("after_err_hdr1", mvb_bus.data, mkh(32'hE0000001, 11'd40));
    pop_both();
    check("after_err_hdr2", mvb_bus.data, mkh(32'hE0000002, 11'd1));
    pop_mvb();

    // reset pulse mid-packet
    send(mkh(32'hF0000001, 11'd20), mkd(16'h0400), 1'b1, 1'b0);
    check("mid_buffered", mfb_bus.src_rdy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("mid_rst_outputs", {mfb_bus.src_rdy, mvb_bus.src_rdy, mvb_bus.vld}, 3'b000);
    check("mid_rst_err", err, 1'b0);
    send(mkh(32'hF0000002, 11'd1), mkd(16'h0401), 1'b1, 1'b1);
    check("mid_new_word", mfbw(), expw(2'b01, 2'b01, 6'b000000, mkd(16'h0401)));
    check("mid_new_hdr", mvb_bus.data, mkh(32'hF0000002, 11'd1));
    check("mid_new_err", err, 1'b0);
    pop_both();
    check("mid_drained", {mfb_bus.src_rdy, mvb_bus.src_rdy}, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
